// File: rtl/fetch_unit.sv
// fetch_unit: holds PC, fetches one word per instruction over a ready handshake, resolves branch/jump/halt
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               halt,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_offset,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [INSTR_W-1:0] instr,
    output logic [7:0]         imm8,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);
    typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALTED} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, seq_pc;
    logic [INSTR_W-1:0] instr_nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            instr <= instr_nxt;
        end
    end
    // pc only advances when EXEC retires unstalled; halt keeps pc on the HALT instruction
    always_comb begin
        state_nxt = state;
        pc_nxt = pc;
        instr_nxt = instr;
        seq_pc = pc + 1'b1;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_nxt = imem_rdata;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_nxt = halt ? HALTED : FETCH;
                    pc_nxt = halt ? pc : jump_en ? jump_target : branch_taken ? seq_pc + branch_offset : seq_pc;
                end
            end
            default: state_nxt = state;
        endcase
    end
    assign imem_req = state == FETCH;
    assign imem_addr = pc;
    assign instr_valid = state == EXEC;
    assign halted = state == HALTED;
    assign imm8 = instr[7:0];
endmodule
